// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 constants, key-event bundle and letter lookup
// used by the key-event controller and its event FIFO.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT_LOW
    } ps2_state_t;

    typedef struct packed {
        logic [4:0] letter;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic [4:0] ps2_letter(input logic [7:0] code);
        logic [4:0] l;
        case (code)
            8'h1C: l = 5'd1;
            8'h32: l = 5'd2;
            8'h21: l = 5'd3;
            8'h23: l = 5'd4;
            8'h24: l = 5'd5;
            8'h2B: l = 5'd6;
            8'h34: l = 5'd7;
            8'h33: l = 5'd8;
            8'h43: l = 5'd9;
            8'h3B: l = 5'd10;
            8'h42: l = 5'd11;
            8'h4B: l = 5'd12;
            8'h3A: l = 5'd13;
            8'h31: l = 5'd14;
            8'h44: l = 5'd15;
            8'h4D: l = 5'd16;
            8'h15: l = 5'd17;
            8'h2D: l = 5'd18;
            8'h1B: l = 5'd19;
            8'h2C: l = 5'd20;
            8'h3C: l = 5'd21;
            8'h2A: l = 5'd22;
            8'h1D: l = 5'd23;
            8'h22: l = 5'd24;
            8'h35: l = 5'd25;
            8'h1A: l = 5'd26;
            default: l = 5'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous key-event FIFO; a pop in the same cycle frees room
// for a push arriving while full.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock50,
    input  logic                     reset,
    input  logic                     i_push,
    input  ps2_evt_t                 i_data,
    input  logic                     i_pop,
    output ps2_evt_t                 o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    ps2_evt_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clock50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 driver handshake, E0/F0 prefix tracking and letter mapping,
// feeding key events into a valid/ready FIFO.
module ps2_key_event_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter bit LETTERS_ONLY = 1'b1
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    output logic       read,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_letter,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [7:0] evt_code,
    output logic       overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ps2_state_t r_state;
    ps2_state_t w_next;
    logic       r_sr_meta;
    logic       r_sr_s;
    logic [7:0] r_code_q;
    logic       r_ext_f;
    logic       r_brk_f;
    logic       r_overflow;

    logic       w_read;
    logic       w_is_ext;
    logic       w_is_brk;
    logic       w_is_evt;
    logic       w_push;
    logic       w_pop;
    ps2_evt_t   w_evt;
    ps2_evt_t   w_head;
    logic       w_full;
    logic       w_empty;
    logic [CW-1:0] w_count;

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_sr_meta <= 1'b0;
            r_sr_s    <= 1'b0;
            r_state   <= IDLE;
        end else begin
            r_sr_meta <= scan_ready;
            r_sr_s    <= r_sr_meta;
            r_state   <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_read = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_sr_s) begin
                    w_read = 1'b1;
                    w_next = DECODE;
                end
            end
            DECODE:   w_next = WAIT_LOW;
            WAIT_LOW: if (!r_sr_s) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_is_ext   = (r_state == DECODE) && (r_code_q == PS2_PREFIX_EXT);
        w_is_brk   = (r_state == DECODE) && (r_code_q == PS2_PREFIX_BRK);
        w_is_evt   = (r_state == DECODE) && !w_is_ext && !w_is_brk;
        // E0-prefixed keys share codes with letters but are never letters
        w_evt.letter = r_ext_f ? 5'd0 : ps2_letter(r_code_q);
        w_evt.brk  = r_brk_f;
        w_evt.ext  = r_ext_f;
        w_evt.code = r_code_q;
        w_push     = w_is_evt && !(LETTERS_ONLY && (w_evt.letter == 5'd0));
        w_pop      = evt_ready && (w_count != '0);
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_code_q   <= 8'h00;
            r_ext_f    <= 1'b0;
            r_brk_f    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_read) begin
                r_code_q <= scan_code;
            end
            if (w_is_ext) begin
                r_ext_f <= 1'b1;
            end
            if (w_is_brk) begin
                r_brk_f <= 1'b1;
            end
            if (w_is_evt) begin
                r_ext_f <= 1'b0;
                r_brk_f <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock50 (clock50),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign read       = w_read;
    assign evt_valid  = !w_empty;
    assign evt_letter = w_head.letter;
    assign evt_break  = w_head.brk;
    assign evt_ext    = w_head.ext;
    assign evt_code   = w_head.code;
    assign overflow   = r_overflow;

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequences the raw PS/2 scan-code driver and turns its byte stream into clean key events for the encryption datapath. It performs the scan_ready/read handshake with the driver and tracks the set-2 E0 (extended) and F0 (break) prefixes. It maps letter keys to indices 1..26 and buffers the resulting events in a small FIFO with a valid/ready output. It sits between the scan-code driver and the cipher/LED consumers.

## Interface
- FIFO_DEPTH, 4, event FIFO depth; power of two, minimum 2.
- LETTERS_ONLY, 1, 1 = discard events whose letter index is 0; 0 = forward every non-prefix code.
- clock50  in  1  50 MHz system clock.
- reset  in  1  reset, synchronous, active-high.
- scan_ready  in  1  driver byte-available flag; asynchronous to clock50.
- scan_code  in  8  driver byte; stable while scan_ready=1.
- read  out  1  one-cycle pulse to the driver that clears scan_ready.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event when evt_valid & evt_ready.
- evt_letter  out  5  0 = non-letter, 1..26 = a..z.
- evt_break  out  1  1 = key release (F0 seen).
- evt_ext  out  1  1 = E0 prefix seen.
- evt_code  out  8  raw final code byte.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- scan_ready passes through a 2-flop synchronizer; the second stage is sr_s.
- Handshake FSM, all states reset to IDLE:
  - IDLE: when sr_s=1, register scan_code into code_q, drive read=1 for this one cycle, go to DECODE.
  - DECODE: process code_q (rules below), go to WAIT_LOW.
  - WAIT_LOW: stay until sr_s=0, then go to IDLE. This means one byte gives exactly one read pulse.
- Prefix decode in DECODE:
  - 0xE0: set ext_f. No event.
  - 0xF0: set brk_f. No event.
  - Any other byte: build the event {letter(code_q), brk_f, ext_f, code_q}, then clear both flags. If ext_f=1, the letter is forced to 0 (E0-prefixed keys are never letters).
- LETTERS_ONLY=1: an event with letter 0 is dropped and its flags are still cleared.
- FIFO behaviour:
  - Push when an event is built and count < FIFO_DEPTH.
  - Pop on evt_valid & evt_ready.
  - Push and pop in the same cycle are both legal when 0 < count < DEPTH, and leave count unchanged.
  - Push while full drops the event and sets overflow. The FIFO contents are unchanged.
  - A pop that is simultaneous with a push while full frees space, so that push is accepted.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Output reset values: read=0, evt_valid=0, evt_letter=0, evt_break=0, evt_ext=0, evt_code=0, overflow=0. Reset also clears the FIFO, ext_f, brk_f and the synchronizer.
- Reset mid-sequence:
  - A partially received prefix (E0/F0 pending) is discarded.
  - If the driver's scan_ready is still high after reset, that byte is re-read as a fresh byte. No partial event is emitted.

## Timing
- Cycle 0: scan_ready rises. Cycle 2: sr_s=1.
- Cycle 2 (IDLE): read=1, code captured.
- Cycle 3: DECODE, push.
- Cycle 4: evt_valid=1.
- Latency from synchronized flag to visible event is 2 cycles.
- evt_* are driven from the FIFO head and are stable while evt_valid=1 and evt_ready=0.
- The read pulse is exactly 1 cycle wide, and there is at most one pulse per sr_s high period.
- WAIT_LOW has no timeout. The driver clears scan_ready within a few cycles of read.
- Throughput is at most one byte per 4 cycles, far above the PS/2 rate.

## Structure
- Package ps2_kbd_pkg:
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - FSM state enum {IDLE, DECODE, WAIT_LOW}.
  - Event struct {letter[4:0], brk, ext, code[7:0]}.
  - Function ps2_letter(code) → 5 bits, using set 2: a=1C b=32 c=21 d=23 e=24 f=2B g=34 h=33 i=43 j=3B k=42 l=4B m=3A n=31 o=44 p=4D q=15 r=2D s=1B t=2C u=3C v=2A w=1D x=22 y=35 z=1A; everything else returns 0.
- One sub-module: ps2_evt_fifo, a synchronous FIFO parameterised by DEPTH, carrying the event struct and producing full/empty/count. The FSM and synchronizer stay in the top module.

## Test plan
- Press "a": scan_code 1C with scan_ready held until read → exactly one read pulse; event letter=1, break=0, ext=0, code=1C appears 2 cycles after sr_s rises.
- Release "z": bytes F0 then 1A → one event with letter=26, break=1; F0 produces no event; two read pulses in total.
- Extended key: E0, 75 with LETTERS_ONLY=0 → ext=1, letter=0, code=75. With LETTERS_ONLY=1 → no event, and flags are cleared so a following 1C gives ext=0.
- Overflow: evt_ready=0, send 5 letter makes with DEPTH=4 → count=4, overflow=1, FIFO head still holds the first letter. Then raise evt_ready → 4 events pop in order.
- Simultaneous push/pop while full: evt_ready=1 in the cycle a new event is built → no drop, overflow stays 0.
- Reset after F0, before the next byte → next byte 24 gives letter=5, break=0. With scan_ready held high across reset → a single read after reset and a single event.
